// File: rtl/fifo_uart_pkg.sv
// Shared constants and FSM encoding for the FIFO-fed UART transmitter.
// Imported by the interface, the bit-period counter and the top.
package fifo_uart_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between an upstream FIFO and the transmitter.
// master = FIFO side, slave = transmitter side.
interface fifo_uart_tx_if
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd_en;

    modport master (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );

    modport slave (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );

endinterface

// File: rtl/fifo_uart_tx_baud_tick_counter.sv
// Bit-period counter: tick marks the last cycle of each serial bit.
// clear holds the count at zero while no bit is being timed.
module baud_tick_counter
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;

    assign tick = (r_count == LAST);

    // Count cycles within a bit; wrap to zero on the last one.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls one word per frame from an upstream FIFO.
// Frame: FETCH, start bit, WIDTH data bits LSB first, stop bit.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tx_en,
    fifo_uart_tx_if.slave  fifo,
    output logic           tx_serial,
    output logic           busy,
    output logic           tx_done
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [IW-1:0]    r_bit;
    logic             r_tx;
    logic             r_done;

    logic             w_tick;
    logic             w_clear;
    logic             w_rd_en;
    logic [WIDTH-1:0] w_shift_nxt;

    // A read is only ever issued from IDLE, and never during reset.
    assign w_rd_en = (r_state == ST_IDLE) && tx_en
                   && !fifo.fifo_empty && !reset;

    assign fifo.fifo_rd_en = w_rd_en;

    // Bit timing restarts from zero when START begins after FETCH.
    assign w_clear = (r_state == ST_IDLE) || (r_state == ST_FETCH);

    assign w_shift_nxt = r_shift >> 1;

    assign busy      = (r_state != ST_IDLE) && !reset;
    assign tx_serial = r_tx;
    assign tx_done   = r_done;

    baud_tick_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // Frame sequencer with registered serial line and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rd_en) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_shift <= fifo.fifo_data;
                    r_tx    <= 1'b0;
                    r_state <= ST_START;
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit == LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_tx    <= w_shift_nxt[0];
                            r_shift <= w_shift_nxt;
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
